// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader
// Loads a kFPGA configuration bitstream from a 16-bit valid/ready stream
// into CHAINS parallel config segments that shift in lock-step. It clears
// the segments, shifts CHAIN_LENGTH payload words, then compares a trailer
// word against a 16-bit running sum of the shifted bits.
//
// Ports:
//   clock, nreset      : clock (rising edge), async active-low reset
//   start, abort       : begin a load / cancel a load in progress
//   s_data, s_valid,
//   s_ready            : configuration stream (valid/ready)
//   config_data        : one serial bit per segment
//   config_enable_out  : shift strobe shared by all segments
//   config_nreset_out  : active-low clear shared by all segments
//   busy, done, error  : load status
//   beat_count         : payload words accepted in the current load

// One config segment's data register: captures its stream bit on a shift.
module kfpga_config_lane (
  input  logic clock,
  input  logic nreset,
  input  logic load,
  input  logic din,
  output logic q
);
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)   q <= 1'b0;
    else if (load) q <= din;
  end
endmodule

module kfpga_config_loader #(
  parameter int CHAINS       = 4,
  parameter int CHAIN_LENGTH = 8672,
  parameter int CLEAR_CYCLES = 4,
  localparam int BW          = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [CHAINS-1:0] config_data,
  output logic              config_enable_out,
  output logic              config_nreset_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [BW-1:0]     beat_count
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(CHAIN_LENGTH - 1);
  // Selects the bits that actually reach the segments.
  localparam logic [15:0]   MASK      = 16'((32'd1 << CHAINS) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] clr_cnt;
  logic [15:0]   checksum;
  logic          in_busy;
  logic          accept;
  logic          shift_en;

  assign in_busy  = (state == S_CLEAR) || (state == S_LOAD) || (state == S_CHECK);
  // Ready is a state decode; abort blocks acceptance in the same cycle.
  assign s_ready  = ((state == S_LOAD) || (state == S_CHECK)) && !abort;
  assign accept   = s_valid && s_ready;
  assign shift_en = accept && (state == S_LOAD);

  kfpga_config_lane u_lane [CHAINS-1:0] (
    .clock  (clock),
    .nreset (nreset),
    .load   (shift_en),
    .din    (s_data[CHAINS-1:0]),
    .q      (config_data)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state             <= S_IDLE;
      clr_cnt           <= '0;
      checksum          <= '0;
      beat_count        <= '0;
      config_enable_out <= 1'b0;
      config_nreset_out <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      config_enable_out <= 1'b0;
      if (abort && in_busy) begin
        // beat_count is left alone so the abort point stays visible.
        state             <= S_IDLE;
        config_nreset_out <= 1'b1;
        busy              <= 1'b0;
        done              <= 1'b0;
        error             <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start && !abort) begin
              state      <= S_CLEAR;
              clr_cnt    <= '0;
              checksum   <= '0;
              beat_count <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
              error      <= 1'b0;
            end
          end
          S_CLEAR: begin
            // The first CLEAR_CYCLES edges drive the clear low; the next
            // one releases it and opens the stream.
            if (clr_cnt == CLR_LAST) begin
              config_nreset_out <= 1'b1;
              state             <= S_LOAD;
            end else begin
              config_nreset_out <= 1'b0;
              clr_cnt           <= clr_cnt + 1'b1;
            end
          end
          S_LOAD: begin
            if (accept) begin
              config_enable_out <= 1'b1;
              beat_count        <= beat_count + 1'b1;
              checksum          <= checksum + (s_data & MASK);
              if (beat_count == BEAT_LAST) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            // Trailer word: compared only, never shifted.
            if (accept) begin
              busy <= 1'b0;
              if (s_data == checksum) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                error <= 1'b1;
                state <= S_ERROR;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_kfpga_config_loader.sv
`timescale 1ns/1ps
module tb_kfpga_config_loader;
  localparam int CH  = 4;
  localparam int LEN = 8;
  localparam int CC  = 4;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [CH-1:0] config_data;
  logic        config_enable_out;
  logic        config_nreset_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  beat_count;

  kfpga_config_loader #(.CHAINS(CH), .CHAIN_LENGTH(LEN), .CLEAR_CYCLES(CC)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .config_data(config_data), .config_enable_out(config_enable_out),
    .config_nreset_out(config_nreset_out), .busy(busy), .done(done),
    .error(error), .beat_count(beat_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Observation of the config pins, sampled mid-cycle.
  int nlow = 0, en_cnt = 0, en_runs = 0;
  logic prev_en = 1'b0;
  logic [CH-1:0] dq[$];
  always @(negedge clock) begin
    if (nreset) begin
      if (!config_nreset_out) nlow++;
      if (config_enable_out) begin
        en_cnt++;
        dq.push_back(config_data);
        if (!prev_en) en_runs++;
      end
      prev_en = config_enable_out;
    end else prev_en = 1'b0;
  end

  int b_nlow, b_en, b_runs, b_dq;
  logic [15:0] wv[LEN];
  int gaps[LEN];

  task automatic snap();
    b_nlow = nlow; b_en = en_cnt; b_runs = en_runs; b_dq = dq.size();
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Present one word after 'gap' idle cycles; hold it until accepted.
  task automatic send_word(input logic [15:0] d, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) step();
    s_data = d; s_valid = 1'b1; n = 0;
    while (!s_ready && n < 50) begin step(); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_word_timeout: s_ready stayed %b", s_ready);
    end
    step();
    s_valid = 1'b0;
  endtask

  // Whole load: start, payload wv[] with gaps[], then trailer.
  task automatic feed(input logic [15:0] tr, input int tgap);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < LEN; i++) send_word(wv[i], gaps[i]);
    send_word(tr, tgap);
  endtask

  function automatic logic [15:0] model_sum();
    int s = 0;
    for (int i = 0; i < LEN; i++) s = (s + (wv[i] % 16)) % 65536;
    return 16'(s);
  endfunction

  function automatic bit data_ok();
    if (dq.size() - b_dq != LEN) return 1'b0;
    for (int i = 0; i < LEN; i++)
      if (dq[b_dq + i] !== wv[i][CH-1:0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [13:0] got;
    nreset = 1'b0; s_valid = 1'b1; s_data = 16'hFFFF;
    #12;
    got = {s_ready, config_data, config_enable_out, config_nreset_out, busy, done, error, beat_count};
    tests++;
    if (got !== 14'b0_0000_0_1_0_0_0_0000) begin
      fails++; $display("FAIL reset_values: got %b want %b", got, 14'b0_0000_0_1_0_0_0_0000);
    end
    #5 nreset = 1'b1;
    snap();
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 20; i++) begin step(); if (s_ready !== 1'b0) bad = 1'b1; end
      tests++;
      if (bad || en_cnt != b_en) begin
        fails++; $display("FAIL reset_idle_ready: s_ready went high or %0d enables", en_cnt - b_en);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_good_load();
    bit bad = 1'b0;
    for (int i = 0; i < LEN; i++) begin wv[i] = 16'(i + 1); gaps[i] = 0; end
    snap();
    start = 1'b1; step(); start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL good_busy: got %b want 1", busy); end
    for (int k = 1; k <= CC + 1; k++) begin
      step();
      if (s_ready !== (k == CC + 1) || config_nreset_out !== (k == CC + 1)) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL good_clear_timing: s_ready/nreset edge wrong"); end
    for (int i = 0; i < LEN; i++) send_word(wv[i], 0);
    send_word(16'h0024, 0);
    tests++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL good_status: done=%b error=%b busy=%b want 1 0 0", done, error, busy);
    end
    tests++;
    if (beat_count !== 4'd8) begin fails++; $display("FAIL good_beat: got %0d want 8", beat_count); end
    tests++;
    if (nlow - b_nlow != CC) begin fails++; $display("FAIL good_clear_len: got %0d want %0d", nlow - b_nlow, CC); end
    tests++;
    if (en_cnt - b_en != LEN || en_runs - b_runs != 1) begin
      fails++; $display("FAIL good_enables: got %0d in %0d runs want 8 in 1", en_cnt - b_en, en_runs - b_runs);
    end
    tests++;
    if (!data_ok()) begin fails++; $display("FAIL good_data: shifted data differs from 1..8"); end
    step();
    tests++;
    if (s_ready !== 1'b0 || done !== 1'b1) begin
      fails++; $display("FAIL good_hold: s_ready=%b done=%b want 0 1", s_ready, done);
    end
  endtask

  task automatic test_bad_checksum();
    for (int i = 0; i < LEN; i++) begin wv[i] = 16'(i + 1); gaps[i] = 0; end
    snap();
    feed(16'h0025, 0);
    tests++;
    if (error !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL bad_status: done=%b error=%b want 0 1", done, error);
    end
    tests++;
    if (en_cnt - b_en != LEN) begin fails++; $display("FAIL bad_enables: got %0d want 8", en_cnt - b_en); end
  endtask

  task automatic test_mask_stall();
    int runs = 0;
    for (int i = 0; i < LEN; i++) begin
      wv[i] = 16'hFFF1; gaps[i] = (i % 2 == 1) ? 2 : 0;
      if (i == 0 || gaps[i] > 0) runs++;
    end
    snap();
    feed(16'h0008, 1);
    tests++;
    if (model_sum() !== 16'h0008 || done !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL mask_status: done=%b error=%b want 1 0", done, error);
    end
    tests++;
    if (en_cnt - b_en != LEN || en_runs - b_runs != runs) begin
      fails++; $display("FAIL mask_enables: got %0d in %0d runs want 8 in %0d", en_cnt - b_en, en_runs - b_runs, runs);
    end
    tests++;
    if (!data_ok()) begin fails++; $display("FAIL mask_data: shifted data not all 0x1"); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < LEN; i++) begin wv[i] = 16'(i + 3); gaps[i] = 0; end
    snap();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(wv[i], 0);
    abort = 1'b1; s_valid = 1'b1; s_data = 16'h0005;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin fails++; $display("FAIL abort_gate: s_ready=%b want 0", s_ready); end
    @(posedge clock); #1;
    abort = 1'b0; s_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || beat_count !== 4'd3 || done !== 1'b0 || config_nreset_out !== 1'b1) begin
      fails++; $display("FAIL abort_state: busy=%b s_ready=%b beat=%0d done=%b want 0 0 3 0", busy, s_ready, beat_count, done);
    end
    repeat (5) step();
    tests++;
    if (en_cnt - b_en != 3) begin fails++; $display("FAIL abort_enables: got %0d want 3", en_cnt - b_en); end
    snap();
    feed(model_sum(), 0);
    tests++;
    if (done !== 1'b1 || en_cnt - b_en != LEN || !data_ok()) begin
      fails++; $display("FAIL abort_reload: done=%b enables=%0d want 1 8", done, en_cnt - b_en);
    end
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < LEN; i++) begin wv[i] = 16'(16'h1230 + i * 5); gaps[i] = 0; end
    snap();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(wv[i], 0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 3; i < LEN; i++) send_word(wv[i], 0);
    send_word(model_sum(), 0);
    tests++;
    if (done !== 1'b1 || beat_count !== 4'd8 || nlow - b_nlow != CC || en_cnt - b_en != LEN) begin
      fails++; $display("FAIL start_busy: done=%b beat=%0d clr=%0d en=%0d want 1 8 4 8", done, beat_count, nlow - b_nlow, en_cnt - b_en);
    end
  endtask

  task automatic test_reset_midload();
    logic [13:0] got;
    for (int i = 0; i < LEN; i++) begin wv[i] = 16'hA5A5; gaps[i] = 0; end
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 2; i++) send_word(wv[i], 0);
    s_valid = 1'b1; s_data = 16'h0007;
    #2 nreset = 1'b0;
    #1;
    got = {s_ready, config_data, config_enable_out, config_nreset_out, busy, done, error, beat_count};
    tests++;
    if (got !== 14'b0_0000_0_1_0_0_0_0000) begin
      fails++; $display("FAIL reset_midload: got %b want %b", got, 14'b0_0000_0_1_0_0_0_0000);
    end
    s_valid = 1'b0;
    step(); #2 nreset = 1'b1;
    step();
    snap();
    feed(model_sum(), 0);
    tests++;
    if (done !== 1'b1 || en_cnt - b_en != LEN) begin
      fails++; $display("FAIL reset_reload: done=%b enables=%0d want 1 8", done, en_cnt - b_en);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [15:0] tr;
      bit good;
      for (int i = 0; i < LEN; i++) begin
        wv[i] = 16'($urandom); gaps[i] = int'($urandom_range(0, 2));
      end
      good = ($urandom_range(0, 1) == 1);
      tr = good ? model_sum() : (model_sum() ^ 16'($urandom_range(1, 16'hFFFF)));
      snap();
      feed(tr, int'($urandom_range(0, 2)));
      tests++;
      if (done !== good || error !== !good || beat_count !== 4'd8) begin
        fails++; $display("FAIL random_status it=%0d: done=%b error=%b beat=%0d want %b %b 8", it, done, error, beat_count, good, !good);
      end
      tests++;
      if (en_cnt - b_en != LEN || !data_ok()) begin
        fails++; $display("FAIL random_data it=%0d: enables=%0d want 8 or data differs", it, en_cnt - b_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_mask_stall();
    test_abort();
    test_start_busy();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
